// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: free-running 24-hour wall clock advanced once per second by a CLK
// prescaler, with validated time-set capture. Define TZ_OFFSET_EN to build LOCAL_DATA.
module rtc_timekeeper #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [17:0]       TIME_SETDATA,
  input  logic              TIME_SET_FLAG,
  input  logic              HOLD,
`ifdef TZ_OFFSET_EN
  input  logic signed [4:0] TZ_OFFSET,
  output logic [17:0]       LOCAL_DATA,
`endif
  output logic [17:0]       CLOCK_DATA,
  output logic              SEC_TICK,
  output logic              DAY_WRAP,
  output logic              LOAD_ERR
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  function automatic logic time_valid(input logic [17:0] t);
    return (t[17:12] <= 6'd23) && (t[11:6] <= 6'd59) && (t[5:0] <= 6'd59);
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;
  logic             load_err_q, load_err_d;
  logic             flag_prev_q;
  logic             armed_q;
  logic             set_req_s;
  logic             load_ok_s;
  logic             tick_s;

  // Request qualification: armed_q masks the first edge after reset so flag_prev syncs first.
  always_comb begin
    set_req_s = armed_q & TIME_SET_FLAG & ~flag_prev_q;
    load_ok_s = set_req_s & time_valid(TIME_SETDATA);
    tick_s    = ~HOLD & (pre_q == PRE_LAST);
  end

  // Next-state for prescaler, time counters and pulses; a valid load overrides a tick.
  always_comb begin
    pre_d      = pre_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    if (load_ok_s) begin
      hour_d = TIME_SETDATA[17:12];
      min_d  = TIME_SETDATA[11:6];
      sec_d  = TIME_SETDATA[5:0];
      pre_d  = '0;
    end else begin
      load_err_d = set_req_s;
      if (tick_s) begin
        pre_d      = '0;
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 6'd23) begin
              hour_d     = 6'd0;
              day_wrap_d = 1'b1;
            end else begin
              hour_d = hour_q + 6'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else if (!HOLD) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = pre_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q       <= '0;
      hour_q      <= 6'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      sec_tick_q  <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
      flag_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_tick_q  <= sec_tick_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
      flag_prev_q <= TIME_SET_FLAG;
      armed_q     <= 1'b1;
    end
  end

  assign CLOCK_DATA = {hour_q, min_q, sec_q};
  assign SEC_TICK   = sec_tick_q;
  assign DAY_WRAP   = day_wrap_q;
  assign LOAD_ERR   = load_err_q;

`ifdef TZ_OFFSET_EN
  logic signed [4:0] tz_clamp_s;
  logic [6:0]        loc_sum_s;
  logic [5:0]        loc_hour_s;
  logic [17:0]       local_q;

  // Clamp the offset to -12..+14 and fold hour+offset into 0..23 (sum is biased by +24).
  always_comb begin
    if (TZ_OFFSET < -5'sd12) begin
      tz_clamp_s = -5'sd12;
    end else if (TZ_OFFSET > 5'sd14) begin
      tz_clamp_s = 5'sd14;
    end else begin
      tz_clamp_s = TZ_OFFSET;
    end
    loc_sum_s = {1'b0, hour_q} + 7'd24 + {{2{tz_clamp_s[4]}}, tz_clamp_s};
    if (loc_sum_s >= 7'd48) begin
      loc_hour_s = 6'(loc_sum_s - 7'd48);
    end else if (loc_sum_s >= 7'd24) begin
      loc_hour_s = 6'(loc_sum_s - 7'd24);
    end else begin
      loc_hour_s = 6'(loc_sum_s);
    end
  end

  // Local time register, one cycle behind CLOCK_DATA.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      local_q <= 18'd0;
    end else begin
      local_q <= {loc_hour_s, min_q, sec_q};
    end
  end

  assign LOCAL_DATA = local_q;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper (TICK_DIV=4): seconds-of-day reference model,
// validity table, directed corner sequences and randomized stimulus.
module tb_rtc_timekeeper;

  localparam int TDIV = 4;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [17:0] TIME_SETDATA = 18'd0;
  logic        TIME_SET_FLAG = 1'b0;
  logic        HOLD = 1'b0;
  logic [17:0] CLOCK_DATA;
  logic        SEC_TICK, DAY_WRAP, LOAD_ERR;
`ifdef TZ_OFFSET_EN
  logic signed [4:0] TZ_OFFSET = 5'sd0;
  logic [17:0]       LOCAL_DATA;
`endif

  rtc_timekeeper #(.TICK_DIV(TDIV), .PRE_W(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .TIME_SETDATA(TIME_SETDATA),
    .TIME_SET_FLAG(TIME_SET_FLAG), .HOLD(HOLD),
`ifdef TZ_OFFSET_EN
    .TZ_OFFSET(TZ_OFFSET), .LOCAL_DATA(LOCAL_DATA),
`endif
    .CLOCK_DATA(CLOCK_DATA), .SEC_TICK(SEC_TICK), .DAY_WRAP(DAY_WRAP), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time kept as seconds since midnight.
  int m_tod, m_pre, m_loc;
  bit m_prev, m_armed, m_tick, m_wrap, m_err;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [17:0] tod2bits(input int t);
    return hms(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_tod = 0; m_pre = 0; m_loc = 0;
    m_prev = 0; m_armed = 0; m_tick = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step();
    int h, m, s, off;
    bit req;
    off = 0;
`ifdef TZ_OFFSET_EN
    off = TZ_OFFSET;
    if (off < -12) off = -12;
    if (off > 14) off = 14;
`endif
    m_loc = ((m_tod + off * 3600) % 86400 + 86400) % 86400;
    h = TIME_SETDATA[17:12]; m = TIME_SETDATA[11:6]; s = TIME_SETDATA[5:0];
    req = m_armed && TIME_SET_FLAG && !m_prev;
    m_armed = 1; m_prev = TIME_SET_FLAG;
    m_tick = 0; m_wrap = 0; m_err = 0;
    if (req && h <= 23 && m <= 59 && s <= 59) begin
      m_tod = h * 3600 + m * 60 + s;
      m_pre = 0;
    end else begin
      m_err = req;
      if (!HOLD) begin
        if (m_pre == TDIV - 1) begin
          m_pre = 0;
          m_tod = (m_tod + 1) % 86400;
          m_tick = 1;
          m_wrap = (m_tod == 0);
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".clock"}, CLOCK_DATA, tod2bits(m_tod));
    chk({tag, ".sec_tick"}, SEC_TICK, m_tick);
    chk({tag, ".day_wrap"}, DAY_WRAP, m_wrap);
    chk({tag, ".load_err"}, LOAD_ERR, m_err);
`ifdef TZ_OFFSET_EN
    chk({tag, ".local"}, LOCAL_DATA, tod2bits(m_loc));
`endif
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all(tag);
  endtask

  typedef struct {
    logic [17:0] data;
    logic        exp_err;
    logic [17:0] exp_clk;
  } load_vec_t;

  load_vec_t lv[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ticks, last_tick, waited;
    logic [17:0] held;

    lv[0] = '{hms(23, 59, 59), 1'b0, hms(23, 59, 59)};
    lv[1] = '{hms(24,  0,  0), 1'b1, hms(23, 59, 59)};
    lv[2] = '{hms( 0,  0,  0), 1'b0, hms( 0,  0,  0)};
    lv[3] = '{hms(12, 60,  0), 1'b1, hms( 0,  0,  0)};
    lv[4] = '{hms(12,  0, 60), 1'b1, hms( 0,  0,  0)};
    lv[5] = '{hms(63, 63, 63), 1'b1, hms( 0,  0,  0)};
    lv[6] = '{hms( 0, 59,  0), 1'b0, hms( 0, 59,  0)};
    lv[7] = '{hms(12, 34, 56), 1'b0, hms(12, 34, 56)};
    lv[8] = '{hms(23,  0, 59), 1'b0, hms(23,  0, 59)};

    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    compare_all("reset");
    RESETN = 1'b1;

    // 1: twelve cycles from reset give three ticks, four cycles apart
    ticks = 0; last_tick = -1;
    for (int i = 0; i < 12; i++) begin
      cyc("tick");
      if (SEC_TICK) begin
        if (last_tick >= 0) chk("tick_spacing", i - last_tick, 4);
        last_tick = i;
        ticks++;
      end
    end
    chk("tick_count", ticks, 3);
    chk("tick_time", CLOCK_DATA, hms(0, 0, 3));

    // 2: day wrap
    TIME_SETDATA = hms(23, 59, 59); TIME_SET_FLAG = 1'b1;
    cyc("wrap_load");
    TIME_SET_FLAG = 1'b0;
    for (int i = 0; i < 3; i++) cyc("wrap_wait");
    chk("wrap_pre", CLOCK_DATA, hms(23, 59, 59));
    cyc("wrap");
    chk("wrap_time", CLOCK_DATA, hms(0, 0, 0));
    chk("wrap_pulse", {DAY_WRAP, SEC_TICK}, 2'b11);
    cyc("wrap_after");
    chk("wrap_one_cycle", DAY_WRAP, 1'b0);

    // 3: set, then hold the flag high with different data
    TIME_SETDATA = hms(12, 34, 56); TIME_SET_FLAG = 1'b1;
    cyc("set");
    chk("set_time", CLOCK_DATA, hms(12, 34, 56));
    TIME_SETDATA = hms(1, 1, 1);
    for (int i = 0; i < 20; i++) cyc("set_level");
    chk("set_level_time", CLOCK_DATA, hms(12, 35, 1));
    TIME_SET_FLAG = 1'b0;
    cyc("set_drop");

    // Validity table, applied under HOLD so time stays put
    HOLD = 1'b1;
    foreach (lv[i]) begin
      TIME_SETDATA = lv[i].data; TIME_SET_FLAG = 1'b1;
      cyc("table");
      chk($sformatf("table%0d_clk", i), CLOCK_DATA, lv[i].exp_clk);
      chk($sformatf("table%0d_err", i), LOAD_ERR, lv[i].exp_err);
      TIME_SET_FLAG = 1'b0;
      cyc("table_gap");
      chk($sformatf("table%0d_err_clear", i), LOAD_ERR, 1'b0);
    end

    // 5a: HOLD for 40 cycles freezes the time
    held = tod2bits(m_tod);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc("hold");
      if (SEC_TICK) ticks++;
    end
    chk("hold_time", CLOCK_DATA, held);
    chk("hold_ticks", ticks, 0);
    HOLD = 1'b0;

    // 5b: load collides with the tick edge
    waited = 0;
    while (m_pre != TDIV - 1 && waited < 8) begin
      cyc("collide_align");
      waited++;
    end
    chk("collide_aligned", m_pre, TDIV - 1);
    TIME_SETDATA = hms(10, 0, 0); TIME_SET_FLAG = 1'b1;
    cyc("collide");
    chk("collide_time", CLOCK_DATA, hms(10, 0, 0));
    chk("collide_no_tick", SEC_TICK, 1'b0);
    TIME_SET_FLAG = 1'b0;
    for (int i = 0; i < 3; i++) cyc("collide_wait");
    chk("collide_wait_time", CLOCK_DATA, hms(10, 0, 0));
    cyc("collide_next");
    chk("collide_next_time", CLOCK_DATA, hms(10, 0, 1));
    chk("collide_next_tick", SEC_TICK, 1'b1);

    // Async reset mid-count, flag already high at release
    cyc("pre_reset");
    #1;
    RESETN = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    chk("async_reset_clock", CLOCK_DATA, 18'd0);
    TIME_SETDATA = hms(7, 7, 7); TIME_SET_FLAG = 1'b1;
    @(negedge CLK);
    RESETN = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_reset");
    chk("flag_level_after_reset", CLOCK_DATA, hms(0, 0, 0));
    TIME_SET_FLAG = 1'b0;
    cyc("post_reset_drop");

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) HOLD = ~HOLD;
      if ($urandom_range(0, 5) == 0) TIME_SET_FLAG = ~TIME_SET_FLAG;
      if ($urandom_range(0, 3) == 0)
        TIME_SETDATA = hms(23, 59, int'($urandom_range(55, 61)));
      else
        TIME_SETDATA = hms(int'($urandom_range(0, 25)), int'($urandom_range(0, 61)),
                           int'($urandom_range(0, 61)));
`ifdef TZ_OFFSET_EN
      TZ_OFFSET = 5'($urandom_range(0, 31));
`endif
      cyc("random");
    end
    HOLD = 1'b0; TIME_SET_FLAG = 1'b0;
    cyc("random_end");

`ifdef TZ_OFFSET_EN
    // 6: local time offsets, including clamping
    HOLD = 1'b1;
    TIME_SETDATA = hms(22, 10, 0); TIME_SET_FLAG = 1'b1; TZ_OFFSET = 5'sd3;
    cyc("tz_load");
    TIME_SET_FLAG = 1'b0;
    cyc("tz_settle");
    chk("tz_plus3", LOCAL_DATA, hms(1, 10, 0));
    TIME_SETDATA = hms(5, 0, 0); TIME_SET_FLAG = 1'b1; TZ_OFFSET = -5'sd12;
    cyc("tz_load2");
    TIME_SET_FLAG = 1'b0;
    cyc("tz_settle2");
    chk("tz_minus12", LOCAL_DATA, hms(17, 0, 0));
    TZ_OFFSET = -5'sd16;
    cyc("tz_clamp_lo");
    chk("tz_clamp_lo", LOCAL_DATA, hms(17, 0, 0));
    TZ_OFFSET = 5'sd15;
    cyc("tz_clamp_hi");
    chk("tz_clamp_hi", LOCAL_DATA, hms(19, 0, 0));
    HOLD = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
